// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared constants and types for the traffic conflict monitor
//
// Purpose: lamp encodings {R,Y,G}, fault cause codes, approach indices and
// the monitor FSM state type, shared by the monitor top and its checkers.
// Ports: none (package).
package traffic_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam logic [2:0] FC_NONE     = 3'b000;
  localparam logic [2:0] FC_ENC      = 3'b001;
  localparam logic [2:0] FC_CONFLICT = 3'b010;
  localparam logic [2:0] FC_SHORT_Y  = 3'b011;
  localparam logic [2:0] FC_SKIP_Y   = 3'b100;

  localparam int M1 = 0;
  localparam int S  = 1;
  localparam int MT = 2;
  localparam int M2 = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// rtl/traffic_conflict_monitor_if.sv - controller-to-lamp bus seen by the monitor
//
// Purpose: groups the controller lights, the fault clear request and the
// lamp/fault outputs of the monitor.
// Signals:
//   light_M1/S/MT/M2  [2:0]  controller lights {R,Y,G}
//   clear_fault              single-cycle request to leave FAULT
//   lamp_M1/S/MT/M2   [2:0]  lamp drive {R,Y,G}
//   fault                    high while in FAULT
//   fault_code        [2:0]  cause of the latched fault
//   fault_src         [3:0]  approaches involved, {M2,MT,S,M1}
// Modports: master = controller side, slave = monitor side.
interface traffic_conflict_monitor_if;
  logic [2:0] light_M1;
  logic [2:0] light_S;
  logic [2:0] light_MT;
  logic [2:0] light_M2;
  logic       clear_fault;
  logic [2:0] lamp_M1;
  logic [2:0] lamp_S;
  logic [2:0] lamp_MT;
  logic [2:0] lamp_M2;
  logic       fault;
  logic [2:0] fault_code;
  logic [3:0] fault_src;

  modport master (
    output light_M1, light_S, light_MT, light_M2, clear_fault,
    input  lamp_M1, lamp_S, lamp_MT, lamp_M2, fault, fault_code, fault_src
  );

  modport slave (
    input  light_M1, light_S, light_MT, light_M2, clear_fault,
    output lamp_M1, lamp_S, lamp_MT, lamp_M2, fault, fault_code, fault_src
  );
endinterface

// File: rtl/approach_checker.sv
// rtl/approach_checker.sv - per-approach encoding and phase transition checks
//
// Purpose: remembers the previous light of one approach and how long it has
// been yellow, and flags invalid encodings, green->red without yellow and
// yellow held for fewer than MIN_YELLOW cycles.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   light   [2:0]   current controller light {R,Y,G}
//   reload          reload history from light and clear the yellow counter
//   is_green        light is green
//   bad_enc         light is not one of red/yellow/green
//   skip_y          green->red transition this cycle
//   short_y         yellow left before MIN_YELLOW cycles
module approach_checker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  input  logic       reload,
  output logic       is_green,
  output logic       bad_enc,
  output logic       skip_y,
  output logic       short_y
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MIN_YELLOW);

  logic [2:0]    prev_q;
  logic [YW-1:0] ycnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= LAMP_RED;
      ycnt_q <= '0;
    end else if (reload) begin
      prev_q <= light;
      ycnt_q <= '0;
    end else begin
      prev_q <= light;
      if (light == LAMP_YEL) begin
        if (ycnt_q != Y_MAX) ycnt_q <= ycnt_q + 1'b1;
      end else begin
        ycnt_q <= '0;
      end
    end
  end

  assign is_green = (light == LAMP_GRN);
  assign bad_enc  = !(light inside {LAMP_RED, LAMP_YEL, LAMP_GRN});
  assign skip_y   = (prev_q == LAMP_GRN) && (light == LAMP_RED);
  // ycnt_q counts the yellow cycles already seen, so leaving yellow is
  // legal once MIN_YELLOW of them have been registered.
  assign short_y  = (prev_q == LAMP_YEL) && (light != LAMP_YEL) && (ycnt_q < Y_MAX);

endmodule

// File: rtl/traffic_conflict_monitor.sv
// rtl/traffic_conflict_monitor.sv - safety monitor between light controller and lamps
//
// Purpose: registers the controller lights onto the lamps, checks encodings,
// green conflicts and phase transitions, and on a violation latches a fault
// and flashes all lamps red until cleared with every input red.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   bus        traffic_conflict_monitor_if.slave (lights in, lamps/fault out)
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW   = 3,
  parameter int FAULT_FILTER = 2,
  parameter int FLASH_DIV    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  traffic_conflict_monitor_if.slave    bus
);

  localparam int FFW = $clog2(FAULT_FILTER + 1);
  localparam logic [FFW-1:0] FILT_MAX  = FFW'(FAULT_FILTER);
  localparam logic [FFW-1:0] FILT_LAST = FFW'(FAULT_FILTER - 1);
  localparam int FLW = $clog2(FLASH_DIV + 1);
  localparam logic [FLW-1:0] FLASH_LAST = FLW'(FLASH_DIV - 1);
  localparam logic [3:0][2:0] ALL_RED = {4{LAMP_RED}};
  localparam logic [3:0][2:0] ALL_OFF = {4{LAMP_OFF}};

  logic [3:0][2:0] light;
  logic [3:0]      is_green, bad_enc, skip_y, short_y;
  logic            reload;

  assign light[M1] = bus.light_M1;
  assign light[S]  = bus.light_S;
  assign light[MT] = bus.light_MT;
  assign light[M2] = bus.light_M2;

  for (genvar i = 0; i < 4; i++) begin : g_appr
    approach_checker #(.MIN_YELLOW(MIN_YELLOW)) u_chk (
      .clk      (clk),
      .rst      (rst),
      .light    (light[i]),
      .reload   (reload),
      .is_green (is_green[i]),
      .bad_enc  (bad_enc[i]),
      .skip_y   (skip_y[i]),
      .short_y  (short_y[i])
    );
  end

  // Conflict matrix: each illegal green pair marks both of its approaches.
  logic [3:0] conf_src;
  always_comb begin
    conf_src = '0;
    if (is_green[S] && is_green[M1]) begin conf_src[S] = 1'b1; conf_src[M1] = 1'b1; end
    if (is_green[S] && is_green[M2]) begin conf_src[S] = 1'b1; conf_src[M2] = 1'b1; end
    if (is_green[S] && is_green[MT]) begin conf_src[S] = 1'b1; conf_src[MT] = 1'b1; end
    if (is_green[MT] && is_green[M2]) begin conf_src[MT] = 1'b1; conf_src[M2] = 1'b1; end
  end

  logic           conflict, enc_bad;
  logic [FFW-1:0] conf_cnt_q, enc_cnt_q;
  logic           conf_trig, enc_trig;

  assign conflict  = |conf_src;
  assign enc_bad   = |bad_enc;
  assign conf_trig = conflict && (conf_cnt_q >= FILT_LAST);
  assign enc_trig  = enc_bad && (enc_cnt_q >= FILT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conf_cnt_q <= '0;
      enc_cnt_q  <= '0;
    end else if (reload) begin
      conf_cnt_q <= '0;
      enc_cnt_q  <= '0;
    end else begin
      if (!conflict) conf_cnt_q <= '0;
      else if (conf_cnt_q != FILT_MAX) conf_cnt_q <= conf_cnt_q + 1'b1;
      if (!enc_bad) enc_cnt_q <= '0;
      else if (enc_cnt_q != FILT_MAX) enc_cnt_q <= enc_cnt_q + 1'b1;
    end
  end

  // Winning cause in priority order.
  logic       trig;
  logic [2:0] win_code;
  logic [3:0] win_src;
  always_comb begin
    trig     = 1'b1;
    win_code = FC_NONE;
    win_src  = '0;
    if (conf_trig) begin
      win_code = FC_CONFLICT; win_src = conf_src;
    end else if (enc_trig) begin
      win_code = FC_ENC;      win_src = bad_enc;
    end else if (|skip_y) begin
      win_code = FC_SKIP_Y;   win_src = skip_y;
    end else if (|short_y) begin
      win_code = FC_SHORT_Y;  win_src = short_y;
    end else begin
      trig = 1'b0;
    end
  end

  state_e          state_q, state_d;
  logic [3:0][2:0] lamp_q, lamp_d;
  logic [2:0]      code_q, code_d;
  logic [3:0]      src_q, src_d;
  logic [FLW-1:0]  flash_cnt_q, flash_cnt_d;
  logic            flash_on_q, flash_on_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    lamp_d      = light;
    code_d      = code_q;
    src_d       = src_q;
    flash_cnt_d = flash_cnt_q;
    flash_on_d  = flash_on_q;
    reload      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (trig) begin
          state_d     = ST_FAULT;
          lamp_d      = ALL_RED;
          code_d      = win_code;
          src_d       = win_src;
          flash_cnt_d = '0;
          flash_on_d  = 1'b1;
        end
      end
      ST_FAULT: begin
        if (bus.clear_fault && (light == ALL_RED)) begin
          state_d = ST_RUN;
          code_d  = FC_NONE;
          src_d   = '0;
          reload  = 1'b1;
        end else begin
          if (flash_cnt_q == FLASH_LAST) begin
            flash_cnt_d = '0;
            flash_on_d  = !flash_on_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 1'b1;
          end
          lamp_d = flash_on_d ? ALL_RED : ALL_OFF;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lamp_q      <= ALL_RED;
      code_q      <= FC_NONE;
      src_q       <= '0;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
    end else begin
      lamp_q      <= lamp_d;
      code_q      <= code_d;
      src_q       <= src_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
    end
  end

  assign bus.lamp_M1    = lamp_q[M1];
  assign bus.lamp_S     = lamp_q[S];
  assign bus.lamp_MT    = lamp_q[MT];
  assign bus.lamp_M2    = lamp_q[M2];
  assign bus.fault      = (state_q == ST_FAULT);
  assign bus.fault_code = code_q;
  assign bus.fault_src  = src_q;

endmodule
